mips_cpu_alu_regs: RTL and testbench

//   Datapath core of the multicycle MIPS bus CPU: 32x32 general register file plus a 32-bit ALU

---
 rtl/mips_cpu_alu_regs_if.sv | 37 +++
 rtl/mips_cpu_alu_regs.sv | 159 +++++++++++++++
 tb/tb_mips_cpu_alu_regs.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_alu_regs_if.sv
// Datapath bus between the multicycle CPU control FSM and the register-file/ALU core.
// The master side (CPU control) drives addresses, operands and opcodes; the slave side returns results.
interface mips_cpu_alu_regs_if;
  logic [3:0]  alu_control;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_sa;
  logic [31:0] alu_r;
  logic        alu_zero;
  logic [2:0]  hilo_op;
  logic [31:0] alu_hi;
  logic [31:0] alu_lo;
  logic        reg_write_enable;
  logic [4:0]  reg_write_address;
  logic [31:0] reg_data_in;
  logic [4:0]  reg_read_address_a;
  logic [31:0] reg_read_data_a;
  logic [4:0]  reg_read_address_b;
  logic [31:0] reg_read_data_b;
  logic [31:0] register_v0;

  modport master (
    output alu_control, alu_a, alu_b, alu_sa, hilo_op,
    output reg_write_enable, reg_write_address, reg_data_in,
    output reg_read_address_a, reg_read_address_b,
    input  alu_r, alu_zero, alu_hi, alu_lo,
    input  reg_read_data_a, reg_read_data_b, register_v0
  );

  modport slave (
    input  alu_control, alu_a, alu_b, alu_sa, hilo_op,
    input  reg_write_enable, reg_write_address, reg_data_in,
    input  reg_read_address_a, reg_read_address_b,
    output alu_r, alu_zero, alu_hi, alu_lo,
    output reg_read_data_a, reg_read_data_b, register_v0
  );
endinterface

// File: rtl/mips_cpu_alu_regs.sv
// MIPS-I datapath core: 32x32 register file, combinational 32-bit ALU and HI/LO mult/div registers.
// Register reads are combinational with no write bypass; $0 always reads zero.
module mips_cpu_alu_regs (
  input logic                  clk,
  input logic                  reset,
  mips_cpu_alu_regs_if.slave   bus
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLLV = 4'b1011;
  localparam logic [3:0] ALU_SRLV = 4'b1100;
  localparam logic [3:0] ALU_SRAV = 4'b1101;
  localparam logic [3:0] ALU_LUI  = 4'b1110;

  localparam logic [2:0] HILO_MULT  = 3'd1;
  localparam logic [2:0] HILO_MULTU = 3'd2;
  localparam logic [2:0] HILO_DIV   = 3'd3;
  localparam logic [2:0] HILO_DIVU  = 3'd4;
  localparam logic [2:0] HILO_MTHI  = 3'd5;
  localparam logic [2:0] HILO_MTLO  = 3'd6;

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] alu_r;
  logic [4:0]  var_sa;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] divisor;
  logic [31:0] quot_s, rem_s;
  logic [31:0] quot_u, rem_u;
  logic        div_by_zero;

  // ALU
  assign var_sa = bus.alu_a[4:0];

  always_comb begin
    alu_r = 32'h0;
    case (bus.alu_control)
      ALU_AND:  alu_r = bus.alu_a & bus.alu_b;
      ALU_OR:   alu_r = bus.alu_a | bus.alu_b;
      ALU_XOR:  alu_r = bus.alu_a ^ bus.alu_b;
      ALU_NOR:  alu_r = ~(bus.alu_a | bus.alu_b);
      ALU_ADD:  alu_r = bus.alu_a + bus.alu_b;
      ALU_SUB:  alu_r = bus.alu_a - bus.alu_b;
      ALU_SLT:  alu_r = {31'h0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      ALU_SLTU: alu_r = {31'h0, bus.alu_a < bus.alu_b};
      ALU_SLL:  alu_r = bus.alu_b << bus.alu_sa;
      ALU_SRL:  alu_r = bus.alu_b >> bus.alu_sa;
      ALU_SRA:  alu_r = $signed(bus.alu_b) >>> bus.alu_sa;
      ALU_SLLV: alu_r = bus.alu_b << var_sa;
      ALU_SRLV: alu_r = bus.alu_b >> var_sa;
      ALU_SRAV: alu_r = $signed(bus.alu_b) >>> var_sa;
      ALU_LUI:  alu_r = {bus.alu_b[15:0], 16'h0};
      default:  alu_r = 32'h0;
    endcase
  end

  assign bus.alu_r    = alu_r;
  assign bus.alu_zero = (alu_r == 32'h0);

  // Divisor forced to 1 on zero so the dividers never see b==0; the result is discarded anyway.
  assign div_by_zero = (bus.alu_b == 32'h0);
  assign divisor     = div_by_zero ? 32'h1 : bus.alu_b;

  always_comb begin
    prod_s = $signed({{32{bus.alu_a[31]}}, bus.alu_a}) * $signed({{32{bus.alu_b[31]}}, bus.alu_b});
    prod_u = {32'h0, bus.alu_a} * {32'h0, bus.alu_b};
    quot_s = $signed(bus.alu_a) / $signed(divisor);
    rem_s  = $signed(bus.alu_a) % $signed(divisor);
    quot_u = bus.alu_a / divisor;
    rem_u  = bus.alu_a % divisor;
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    case (bus.hilo_op)
      HILO_MULT: begin
        hi_d = prod_s[63:32];
        lo_d = prod_s[31:0];
      end
      HILO_MULTU: begin
        hi_d = prod_u[63:32];
        lo_d = prod_u[31:0];
      end
      HILO_DIV: begin
        if (!div_by_zero) begin
          hi_d = rem_s;
          lo_d = quot_s;
        end
      end
      HILO_DIVU: begin
        if (!div_by_zero) begin
          hi_d = rem_u;
          lo_d = quot_u;
        end
      end
      HILO_MTHI: hi_d = bus.alu_a;
      HILO_MTLO: lo_d = bus.alu_a;
      default: begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= 32'h0;
      lo_q <= 32'h0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign bus.alu_hi = hi_q;
  assign bus.alu_lo = lo_q;

  // Register file
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (bus.reg_write_enable && (bus.reg_write_address != 5'd0)) begin
      regs_d[bus.reg_write_address] = bus.reg_data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign bus.reg_read_data_a = (bus.reg_read_address_a == 5'd0) ? 32'h0 : regs_q[bus.reg_read_address_a];
  assign bus.reg_read_data_b = (bus.reg_read_address_b == 5'd0) ? 32'h0 : regs_q[bus.reg_read_address_b];
  assign bus.register_v0     = regs_q[2];

endmodule

// File: tb/tb_mips_cpu_alu_regs.sv
// Directed bench for the MIPS register file / ALU / HI-LO datapath core.
module tb_mips_cpu_alu_regs;

  logic clk;
  logic reset;
  int   vectors_applied;
  int   miscompares;

  mips_cpu_alu_regs_if bus ();

  mips_cpu_alu_regs dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sa;
    logic [31:0] r;
  } alu_vec_t;

  alu_vec_t vecs [16];

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors_applied++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    bus.reg_write_enable  = 1'b1;
    bus.reg_write_address = addr;
    bus.reg_data_in       = data;
    tick();
    bus.reg_write_enable  = 1'b0;
  endtask

  task automatic do_hilo(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.hilo_op = op;
    bus.alu_a   = a;
    bus.alu_b   = b;
    tick();
    bus.hilo_op = 3'd0;
  endtask

  initial begin
    vectors_applied = 0;
    miscompares     = 0;

    vecs[0]  = '{4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h00F000F0};
    vecs[1]  = '{4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'hFFF0FFF0};
    vecs[2]  = '{4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'hFF00FF00};
    vecs[3]  = '{4'b0011, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF};
    vecs[4]  = '{4'b0100, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000};
    vecs[5]  = '{4'b0101, 32'h00000005, 32'h00000007, 5'd0,  32'hFFFFFFFE};
    vecs[6]  = '{4'b0110, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001};
    vecs[7]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000};
    vecs[8]  = '{4'b1000, 32'h00000000, 32'h00000001, 5'd31, 32'h80000000};
    vecs[9]  = '{4'b1001, 32'h00000000, 32'h80000000, 5'd4,  32'h08000000};
    vecs[10] = '{4'b1010, 32'h00000000, 32'h80000000, 5'd4,  32'hF8000000};
    vecs[11] = '{4'b1011, 32'h00000024, 32'h0000000F, 5'd0,  32'h000000F0};
    vecs[12] = '{4'b1100, 32'h00000021, 32'h80000000, 5'd9,  32'h40000000};
    vecs[13] = '{4'b1101, 32'h0000003F, 32'h80000000, 5'd0,  32'hFFFFFFFF};
    vecs[14] = '{4'b1110, 32'h00000000, 32'hFFFF1234, 5'd0,  32'h12340000};
    vecs[15] = '{4'b1111, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000};

    reset                  = 1'b0;
    bus.alu_control        = 4'b1111;
    bus.alu_a              = 32'h0;
    bus.alu_b              = 32'h0;
    bus.alu_sa             = 5'd0;
    bus.hilo_op            = 3'd0;
    bus.reg_write_enable   = 1'b0;
    bus.reg_write_address  = 5'd0;
    bus.reg_data_in        = 32'h0;
    bus.reg_read_address_a = 5'd2;
    bus.reg_read_address_b = 5'd31;

    // Writes and MTHI while held in reset must be ignored
    #3;
    bus.hilo_op = 3'd5;
    bus.alu_a   = 32'h77777777;
    write_reg(5'd2, 32'h55555555);
    bus.hilo_op = 3'd0;
    check_vec("rst_read_a", bus.reg_read_data_a, 32'h0);
    check_vec("rst_read_b", bus.reg_read_data_b, 32'h0);
    check_vec("rst_v0", bus.register_v0, 32'h0);
    check_vec("rst_hi", bus.alu_hi, 32'h0);
    check_vec("rst_lo", bus.alu_lo, 32'h0);

    reset = 1'b1;
    tick();

    // No bypass: the new value must not appear before the edge
    bus.reg_write_enable  = 1'b1;
    bus.reg_write_address = 5'd2;
    bus.reg_data_in       = 32'h12345678;
    #1;
    check_vec("v0_before_edge", bus.register_v0, 32'h0);
    check_vec("rda_before_edge", bus.reg_read_data_a, 32'h0);
    tick();
    bus.reg_write_enable = 1'b0;
    check_vec("v0_after_edge", bus.register_v0, 32'h12345678);
    check_vec("rda_after_edge", bus.reg_read_data_a, 32'h12345678);

    write_reg(5'd0, 32'hFFFFFFFF);
    bus.reg_read_address_a = 5'd0;
    #1;
    check_vec("r0_reads_zero", bus.reg_read_data_a, 32'h0);

    write_reg(5'd31, 32'hDEADBEEF);
    bus.reg_read_address_a = 5'd31;
    bus.reg_read_address_b = 5'd31;
    #1;
    check_vec("r31_port_a", bus.reg_read_data_a, 32'hDEADBEEF);
    check_vec("r31_port_b", bus.reg_read_data_b, 32'hDEADBEEF);
    check_vec("v0_held", bus.register_v0, 32'h12345678);

    for (int i = 0; i < 16; i++) begin
      bus.alu_control = vecs[i].ctrl;
      bus.alu_a       = vecs[i].a;
      bus.alu_b       = vecs[i].b;
      bus.alu_sa      = vecs[i].sa;
      #1;
      check_vec($sformatf("alu_r_op%0d", i), bus.alu_r, vecs[i].r);
      check_vec($sformatf("alu_zero_op%0d", i), {31'h0, bus.alu_zero}, {31'h0, vecs[i].r == 32'h0});
    end

    do_hilo(3'd5, 32'h11111111, 32'h0);
    do_hilo(3'd6, 32'h22222222, 32'h0);
    check_vec("mthi", bus.alu_hi, 32'h11111111);
    check_vec("mtlo", bus.alu_lo, 32'h22222222);

    do_hilo(3'd1, 32'hFFFFFFFD, 32'h00000007);
    check_vec("mult_hi", bus.alu_hi, 32'hFFFFFFFF);
    check_vec("mult_lo", bus.alu_lo, 32'hFFFFFFEB);

    do_hilo(3'd2, 32'hFFFFFFFF, 32'h00000002);
    check_vec("multu_hi", bus.alu_hi, 32'h00000001);
    check_vec("multu_lo", bus.alu_lo, 32'hFFFFFFFE);

    do_hilo(3'd3, 32'hFFFFFFF9, 32'h00000002);
    check_vec("div_lo", bus.alu_lo, 32'hFFFFFFFD);
    check_vec("div_hi", bus.alu_hi, 32'hFFFFFFFF);

    do_hilo(3'd4, 32'h00000007, 32'h00000002);
    check_vec("divu_lo", bus.alu_lo, 32'h00000003);
    check_vec("divu_hi", bus.alu_hi, 32'h00000001);

    do_hilo(3'd4, 32'h00000009, 32'h00000000);
    check_vec("divu_b0_lo", bus.alu_lo, 32'h00000003);
    check_vec("divu_b0_hi", bus.alu_hi, 32'h00000001);

    do_hilo(3'd3, 32'h00000009, 32'h00000000);
    do_hilo(3'd7, 32'h12121212, 32'h34343434);
    do_hilo(3'd0, 32'h56565656, 32'h78787878);
    check_vec("hold_lo", bus.alu_lo, 32'h00000003);
    check_vec("hold_hi", bus.alu_hi, 32'h00000001);

    // Register write and HI/LO op in the same cycle
    bus.reg_read_address_a = 5'd5;
    bus.reg_write_enable   = 1'b1;
    bus.reg_write_address  = 5'd5;
    bus.reg_data_in        = 32'hCAFEF00D;
    do_hilo(3'd6, 32'h33333333, 32'h0);
    bus.reg_write_enable   = 1'b0;
    check_vec("same_cycle_reg", bus.reg_read_data_a, 32'hCAFEF00D);
    check_vec("same_cycle_lo", bus.alu_lo, 32'h33333333);

    do_hilo(3'd5, 32'hA5A5A5A5, 32'h0);
    check_vec("mthi_a5", bus.alu_hi, 32'hA5A5A5A5);

    // Async reset pulse between edges, with a write pending
    bus.reg_write_enable  = 1'b1;
    bus.reg_write_address = 5'd2;
    bus.reg_data_in       = 32'h99999999;
    #2;
    reset = 1'b0;
    #1;
    check_vec("async_hi", bus.alu_hi, 32'h0);
    check_vec("async_lo", bus.alu_lo, 32'h0);
    check_vec("async_v0", bus.register_v0, 32'h0);
    check_vec("async_r5", bus.reg_read_data_a, 32'h0);
    tick();
    check_vec("rst_pending_write", bus.register_v0, 32'h0);
    bus.reg_write_enable = 1'b0;
    reset = 1'b1;
    tick();
    check_vec("post_rst_v0", bus.register_v0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
